mipse_cpu: RTL and testbench



---
 rtl/mipse_cpu.sv | 174 +++++++++++++++++
 tb/tb_mipse_cpu.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipse_cpu.sv
// mipse_cpu: single-cycle 32-bit MIPS-subset core with Harvard memory ports.
// One instruction is fetched, executed and retired per rising edge of clk.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   instr        instruction word at pc (combinational imem read)
//   readdata     data word at aluresult (combinational dmem read)
//   pc           current instruction address
//   aluresult    ALU output, also the data-memory byte address
//   writedata    store data (rt register value)
//   memwrite     high for sw; dmem commits on the rising edge

// mipse_regfile: 32 x DATA_W register file, two combinational reads, one write.
// Ports: clk, rst_n, we/wa/wd write port, ra1/ra2 read addresses, rd1/rd2 data.
module mipse_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] rf [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      rf[wa] <= wd;
    end
  end

  // Register 0 is hard-wired to zero on the read side as well.
  assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
endmodule

module mipse_cpu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] aluresult,
  output logic [DATA_W-1:0] writedata,
  output logic              memwrite
);
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, shamt, wa;
  logic [DATA_W-1:0] sext_imm, zext_imm, pc_plus4, br_target, jmp_target;
  logic [DATA_W-1:0] rs_val, rt_val, alu_res, result;
  logic [7:0]        lb_byte;
  logic              reg_we, mem_wr, lw_op, lb_op, link;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign sext_imm = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign zext_imm = {{(DATA_W-16){1'b0}}, instr[15:0]};

  assign pc_plus4   = pc_q + DATA_W'(4);
  assign br_target  = pc_plus4 + {sext_imm[DATA_W-3:0], 2'b00};
  assign jmp_target = {pc_plus4[DATA_W-1:28], instr[25:0], 2'b00};

  mipse_regfile #(.DATA_W(DATA_W)) rfile_1 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (reg_we),
    .ra1  (rs),
    .ra2  (rt),
    .wa   (wa),
    .wd   (result),
    .rd1  (rs_val),
    .rd2  (rt_val)
  );

  always_comb begin
    alu_res = '0;
    reg_we  = 1'b0;
    wa      = rt;
    mem_wr  = 1'b0;
    lw_op   = 1'b0;
    lb_op   = 1'b0;
    link    = 1'b0;
    pc_d    = pc_plus4;
    case (op)
      6'h00: begin
        wa     = rd;
        reg_we = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_res = rs_val + rt_val;
          6'h22, 6'h23: alu_res = rs_val - rt_val;
          6'h24:        alu_res = rs_val & rt_val;
          6'h25:        alu_res = rs_val | rt_val;
          6'h26:        alu_res = rs_val ^ rt_val;
          6'h27:        alu_res = ~(rs_val | rt_val);
          6'h2a:        alu_res = {{(DATA_W-1){1'b0}}, $signed(rs_val) < $signed(rt_val)};
          6'h2b:        alu_res = {{(DATA_W-1){1'b0}}, rs_val < rt_val};
          6'h00:        alu_res = rt_val << shamt;
          6'h02:        alu_res = rt_val >> shamt;
          6'h03:        alu_res = $unsigned($signed(rt_val) >>> shamt);
          6'h08: begin
            reg_we = 1'b0;
            pc_d   = rs_val;
          end
          default:      reg_we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin alu_res = rs_val + sext_imm; reg_we = 1'b1; end
      6'h0a: begin
        alu_res = {{(DATA_W-1){1'b0}}, $signed(rs_val) < $signed(sext_imm)};
        reg_we  = 1'b1;
      end
      6'h0b: begin
        alu_res = {{(DATA_W-1){1'b0}}, rs_val < sext_imm};
        reg_we  = 1'b1;
      end
      6'h0c: begin alu_res = rs_val & zext_imm; reg_we = 1'b1; end
      6'h0d: begin alu_res = rs_val | zext_imm; reg_we = 1'b1; end
      6'h0e: begin alu_res = rs_val ^ zext_imm; reg_we = 1'b1; end
      6'h0f: begin alu_res = {instr[15:0], 16'h0000}; reg_we = 1'b1; end
      6'h23: begin alu_res = rs_val + sext_imm; reg_we = 1'b1; lw_op = 1'b1; end
      6'h20: begin alu_res = rs_val + sext_imm; reg_we = 1'b1; lb_op = 1'b1; end
      6'h2b: begin alu_res = rs_val + sext_imm; mem_wr = 1'b1; end
      6'h04: if (rs_val == rt_val) pc_d = br_target;
      6'h05: if (rs_val != rt_val) pc_d = br_target;
      6'h02: pc_d = jmp_target;
      6'h03: begin
        pc_d   = jmp_target;
        reg_we = 1'b1;
        wa     = 5'd31;
        link   = 1'b1;
      end
      default: ;
    endcase
  end

  // Little-endian byte lane pick for lb.
  always_comb begin
    case (alu_res[1:0])
      2'd0:    lb_byte = readdata[7:0];
      2'd1:    lb_byte = readdata[15:8];
      2'd2:    lb_byte = readdata[23:16];
      default: lb_byte = readdata[31:24];
    endcase
  end

  always_comb begin
    if (link)       result = pc_plus4;
    else if (lw_op) result = readdata;
    else if (lb_op) result = {{(DATA_W-8){lb_byte[7]}}, lb_byte};
    else            result = alu_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc        = pc_q;
  assign aluresult = alu_res;
  assign writedata = rt_val;
  assign memwrite  = mem_wr;
endmodule

// File: tb/tb_mipse_cpu.sv
// tb_mipse_cpu: scoreboard bench for mipse_cpu. A stimulus process loads
// programs, steps an instruction-level reference model and queues the
// expected per-cycle state; a monitor process pops and compares.
module tb_mipse_cpu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmem_clr = 1'b1;
  logic        done = 1'b0;
  logic [31:0] instr, readdata, pc, aluresult, writedata;
  logic        memwrite;

  mipse_cpu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .readdata (readdata),
    .pc       (pc),
    .aluresult(aluresult),
    .writedata(writedata),
    .memwrite (memwrite)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [65536];
  logic [31:0] dmem [65536];

  assign instr    = imem[pc[17:2]];
  assign readdata = dmem[aluresult[17:2]];

  always @(posedge clk) begin
    if (dmem_clr) begin
      for (int i = 0; i < 65536; i++) dmem[i] <= 32'h0;
    end else if (rst_n && memwrite) begin
      dmem[aluresult[17:2]] <= writedata;
    end
  end

  localparam int K_STEP = 0, K_RESET = 1, K_REG = 2, K_PC = 3;

  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic        mw;
    logic        lb;
    logic        chk_addr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          idx;
    logic [31:0] val;
    logic [31:0] regs [32];
  } exp_t;

  exp_t sb [$];

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  logic [31:0] m_dmem [65536];
  logic [31:0] m_pc;

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  task automatic model_step(output exp_t e);
    logic [31:0] ins, a, b, se, ze, npc, wv, addr, w;
    logic [7:0]  bt;
    logic [5:0]  opc, fn;
    int          rsn, rtn, rdn, sh, wa;
    logic        wr;
    ins = imem[m_pc[17:2]];
    opc = ins[31:26]; fn = ins[5:0];
    rsn = int'(ins[25:21]); rtn = int'(ins[20:16]); rdn = int'(ins[15:11]);
    sh  = int'(ins[10:6]);
    a = m_rf[rsn]; b = m_rf[rtn];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    e.kind = K_STEP; e.pc = m_pc; e.mw = 1'b0; e.lb = 1'b0; e.chk_addr = 1'b0;
    e.addr = 32'h0; e.wd = 32'h0; e.idx = 0; e.val = 32'h0;
    for (int i = 0; i < 32; i++) e.regs[i] = m_rf[i];
    npc = m_pc + 32'd4; wr = 1'b0; wa = rtn; wv = 32'h0; addr = a + se;
    case (opc)
      6'h00: begin
        wa = rdn; wr = 1'b1;
        case (fn)
          6'h20, 6'h21: wv = a + b;
          6'h22, 6'h23: wv = a - b;
          6'h24: wv = a & b;
          6'h25: wv = a | b;
          6'h26: wv = a ^ b;
          6'h27: wv = ~(a | b);
          6'h2a: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2b: wv = (a < b) ? 32'd1 : 32'd0;
          6'h00: wv = b << sh;
          6'h02: wv = b >> sh;
          6'h03: wv = $unsigned($signed(b) >>> sh);
          6'h08: begin wr = 1'b0; npc = a; end
          default: wr = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin wr = 1'b1; wv = a + se; end
      6'h0a: begin wr = 1'b1; wv = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0b: begin wr = 1'b1; wv = (a < se) ? 32'd1 : 32'd0; end
      6'h0c: begin wr = 1'b1; wv = a & ze; end
      6'h0d: begin wr = 1'b1; wv = a | ze; end
      6'h0e: begin wr = 1'b1; wv = a ^ ze; end
      6'h0f: begin wr = 1'b1; wv = ze << 16; end
      6'h23: begin
        wr = 1'b1; wv = m_dmem[addr[17:2]];
        e.chk_addr = 1'b1; e.addr = addr;
      end
      6'h20: begin
        w  = m_dmem[addr[17:2]];
        bt = w[8*int'(addr[1:0]) +: 8];
        wr = 1'b1; wv = {{24{bt[7]}}, bt};
        e.chk_addr = 1'b1; e.addr = addr; e.lb = 1'b1;
      end
      6'h2b: begin
        e.chk_addr = 1'b1; e.addr = addr; e.mw = 1'b1; e.wd = b;
        m_dmem[addr[17:2]] = b;
      end
      6'h04: if (a == b) npc = m_pc + 32'd4 + (se << 2);
      6'h05: if (a != b) npc = m_pc + 32'd4 + (se << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin
        wr = 1'b1; wa = 31; wv = m_pc + 32'd4;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    if (wr && wa != 0) m_rf[wa] = wv;
    m_pc = npc;
  endtask

  // ---------------- program construction ----------------
  logic [31:0] prog [$];

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt,
                                        input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 4096; i++) imem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
  endtask

  task automatic run_prog(input int n);
    exp_t e;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      model_step(e);
      sb.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic push_reg(input int idx, input logic [31:0] val);
    exp_t e;
    e.kind = K_REG; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_pc(input logic [31:0] val);
    exp_t e;
    e.kind = K_PC; e.val = val;
    sb.push_back(e);
  endtask

  task automatic build_prog2();
    prog.delete();
    prog.push_back(enc_i(8'h08, 0, 1, 4));
    prog.push_back(enc_i(8'h08, 0, 2, 0));
    prog.push_back(enc_i(8'h08, 2, 2, 1));
    prog.push_back(enc_i(8'h08, 1, 1, -1));
    prog.push_back(enc_i(8'h05, 1, 0, -3));
    prog.push_back(enc_i(8'h04, 1, 2, 5));
    prog.push_back(enc_j(8'h03, 10));
    prog.push_back(enc_i(8'h08, 0, 3, 7));
    prog.push_back(enc_j(8'h02, 8));
    prog.push_back(32'h0);
    prog.push_back(enc_i(8'h08, 0, 4, 9));
    prog.push_back(enc_r(31, 0, 0, 0, 8'h08));
    load_prog();
  endtask

  task automatic build_random();
    int fns [14] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                     'h2a, 'h2b, 'h00, 'h02, 'h03, 'h3f};
    int iops [8] = '{'h08, 'h09, 'h0a, 'h0b, 'h0c, 'h0d, 'h0e, 'h0f};
    int sel, r1, r2, r3;
    prog.delete();
    for (int i = 1; i < 9; i++) begin
      prog.push_back(enc_i(8'h0f, 0, i, int'($urandom_range(0, 65535))));
      prog.push_back(enc_i(8'h0d, i, i, int'($urandom_range(0, 65535))));
    end
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      r1 = int'($urandom_range(0, 15));
      r2 = int'($urandom_range(0, 15));
      r3 = int'($urandom_range(0, 15));
      case (sel)
        0, 1, 2: prog.push_back(enc_r(r1, r2, r3, int'($urandom_range(0, 31)),
                                      fns[$urandom_range(0, 13)]));
        3, 4: prog.push_back(enc_i(iops[$urandom_range(0, 7)], r1, r2,
                                   int'($urandom_range(0, 65535))));
        5: prog.push_back(enc_i(8'h23, ($urandom_range(0, 1) == 1) ? r1 : 0, r2,
                                int'($urandom_range(0, 65535))));
        6: prog.push_back(enc_i(8'h20, ($urandom_range(0, 1) == 1) ? r1 : 0, r2,
                                int'($urandom_range(0, 65535))));
        7: prog.push_back(enc_i(8'h2b, ($urandom_range(0, 1) == 1) ? r1 : 0, r2,
                                int'($urandom_range(0, 65535))));
        8: prog.push_back(enc_i(($urandom_range(0, 1) == 1) ? 8'h04 : 8'h05, r1, r2,
                                int'($urandom_range(0, 3))));
        default:
          if ($urandom_range(0, 1) == 1)
            prog.push_back(enc_j(8'h02, prog.size() + int'($urandom_range(1, 3))));
          else
            prog.push_back(enc_i(8'h3f, r1, r2, int'($urandom_range(0, 65535))));
      endcase
    end
    load_prog();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    for (int i = 0; i < 65536; i++) begin
      m_dmem[i] = 32'h0;
      imem[i]   = 32'h0;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    dmem_clr = 1'b0;

    // Arithmetic, memory round trip, lb lanes, termination store.
    prog.delete();
    prog.push_back(enc_i(8'h08, 0, 1, 5));
    prog.push_back(enc_i(8'h08, 0, 2, -3));
    prog.push_back(enc_r(1, 2, 3, 0, 8'h20));
    prog.push_back(enc_r(1, 2, 4, 0, 8'h22));
    prog.push_back(enc_r(2, 1, 5, 0, 8'h2a));
    prog.push_back(enc_i(8'h2b, 0, 1, 'h400));
    prog.push_back(enc_i(8'h23, 0, 6, 'h400));
    prog.push_back(enc_i(8'h0f, 0, 8, 'h80FF));
    prog.push_back(enc_i(8'h0d, 8, 8, 'h7F01));
    prog.push_back(enc_i(8'h2b, 0, 8, 'h400));
    prog.push_back(enc_i(8'h20, 0, 9, 'h400));
    prog.push_back(enc_i(8'h20, 0, 10, 'h401));
    prog.push_back(enc_i(8'h20, 0, 11, 'h403));
    prog.push_back(enc_i(8'h08, 0, 7, 'h7fff));
    prog.push_back(enc_i(8'h2b, 7, 1, 0));
    load_prog();
    run_prog(18);
    push_reg(3, 32'd2);
    push_reg(4, 32'd8);
    push_reg(5, 32'd1);
    push_reg(6, 32'd5);
    push_reg(8, 32'h80FF7F01);
    push_reg(9, 32'h00000001);
    push_reg(10, 32'h0000007F);
    push_reg(11, 32'hFFFFFF80);
    push_reg(7, 32'h00007fff);
    push_pc(32'h48);

    // Control flow, interrupted mid-loop by reset, then run to completion.
    build_prog2();
    run_prog(7);
    rst_n = 1'b0;
    e.kind = K_RESET; e.pc = 32'h0;
    for (int i = 0; i < 32; i++) e.regs[i] = 32'h0;
    sb.push_back(e);
    model_reset();
    run_prog(24);
    push_reg(1, 32'd0);
    push_reg(2, 32'd4);
    push_reg(31, 32'd28);
    push_reg(3, 32'd7);
    push_reg(4, 32'd9);
    push_pc(32'd32);

    for (int p = 0; p < 4; p++) begin
      build_random();
      run_prog(80);
    end

    @(negedge clk);
    done = 1'b1;
  end

  // ---------------- monitor ----------------
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t me;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_regs(input exp_t e);
    int bad;
    bad = -1;
    for (int i = 31; i >= 0; i--)
      if (dut.rfile_1.rf[i] !== e.regs[i]) bad = i;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL regs: r%0d got 0x%08h expected 0x%08h (pc 0x%08h, t=%0t)",
               bad, dut.rfile_1.rf[bad], e.regs[bad], e.pc, $time);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    cyc++;
    while (sb.size() > 0) begin
      me = sb.pop_front();
      case (me.kind)
        K_STEP: begin
          check("pc", pc, me.pc);
          check("memwrite", {31'b0, memwrite}, {31'b0, me.mw});
          check("lb_op", {31'b0, dut.lb_op}, {31'b0, me.lb});
          if (me.chk_addr) check("aluresult", aluresult, me.addr);
          if (me.mw) check("writedata", writedata, me.wd);
          check_regs(me);
        end
        K_RESET: begin
          check("reset_pc", pc, 32'h0);
          check_regs(me);
        end
        K_REG: check($sformatf("reg_r%0d", me.idx), dut.rfile_1.rf[me.idx], me.val);
        default: check("final_pc", pc, me.val);
      endcase
    end
    if (cyc > 20000) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d cycles expected at most 20000", cyc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
    if (done) begin
      check("drain", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end
endmodule
